stagemem: RTL

Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. It consumes the EX/MEM-registered ALU result (effective address), rs2 store data and load/store control. It performs one data-memory transaction per load/store over a req/ready bus, formats load data, and holds the pipeline via `o_stall` until the access completes. It also flags misaligned accesses and bus timeouts.

---
 rtl/stagemem_pkg.sv | 47 ++++
 rtl/stagemem_ldformat.sv | 28 ++
 rtl/stagemem.sv | 111 +++++++++++
 3 files changed

// File: rtl/stagemem_pkg.sv
// Shared definitions for the MEM stage: funct3 access encodings, FSM states,
// and the byte-enable / store-lane helpers used when an access is launched.
package mempkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bytes never misalign; halves need addr[0]=0; everything else is a word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LB, LBU: return 1'b0;
      LH, LHU: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      LB, LBU: return 4'b0001 << lo;
      LH, LHU: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      SB:      return {4{rs2[7:0]}};
      SH:      return {2{rs2[15:0]}};
      SW:      return rs2;
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/stagemem_ldformat.sv
// Load formatter: picks the byte/half lane of a read word by address offset
// and sign- or zero-extends it according to funct3.
module ldformat
  import mempkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata >> {addr_lo, 3'b000});
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_lane[7]}}, byte_lane};
      LH:      data = {{16{half_lane[15]}}, half_lane};
      LBU:     data = {24'd0, byte_lane};
      LHU:     data = {16'd0, half_lane};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/stagemem.sv
// MEM stage of the RV32I pipeline: one bus transaction per load/store,
// stalling upstream stages until the access completes or times out.
module stagemem
  import mempkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_alu_data_mem,
  input  logic [31:0] i_rs2_data_mem,
  input  logic        i_mem_rden_mem,
  input  logic        i_mem_wren_mem,
  input  logic [2:0]  i_funct3_mem,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic [31:0] o_ld_data,
  output logic        o_stall,
  output logic        o_misalign,
  output logic        o_bus_err,
  output state_e      o_state
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_e      state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [1:0]  lat_lo;
  logic [2:0]  lat_f3;
  logic        op;
  logic        mis;
  logic        start;
  logic [31:0] fmt_data;

  assign op      = i_mem_rden_mem | i_mem_wren_mem;
  assign mis     = is_misaligned(i_funct3_mem, i_alu_data_mem[1:0]);
  assign start   = (state == IDLE) && op && !mis;
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // The launch cycle stalls combinationally so the EX/MEM inputs hold into BUSY.
  assign o_stall    = !i_reset && (start || state == BUSY);
  assign o_misalign = !i_reset && (state == IDLE) && op && mis;
  assign o_state    = state;

  ldformat u_ldformat (
    .rdata   (i_dmem_rdata),
    .addr_lo (lat_lo),
    .funct3  (lat_f3),
    .data    (fmt_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      lat_lo       <= 2'd0;
      lat_f3       <= 3'd0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= 32'd0;
      o_dmem_wdata <= 32'd0;
      o_dmem_be    <= 4'd0;
      o_ld_data    <= 32'd0;
      o_bus_err    <= 1'b0;
    end else begin
      o_bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= BUSY;
            cnt          <= 8'd0;
            lat_lo       <= i_alu_data_mem[1:0];
            lat_f3       <= i_funct3_mem;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_wren_mem;
            o_dmem_addr  <= {i_alu_data_mem[31:2], 2'b00};
            o_dmem_wdata <= lane_data(i_funct3_mem, i_rs2_data_mem);
            o_dmem_be    <= byte_en(i_funct3_mem, i_alu_data_mem[1:0]);
          end
        end
        BUSY: begin
          cnt <= cnt_inc;
          // Ready takes priority over a timeout landing on the same edge.
          if (i_dmem_ready || cnt_inc == TMO) begin
            state        <= DONE;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_be    <= 4'd0;
            if (i_dmem_ready) begin
              if (!o_dmem_we) o_ld_data <= fmt_data;
            end else begin
              o_bus_err <= 1'b1;
              o_ld_data <= 32'd0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
